// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with a valid/ready handshake on both sides.
//            Logic, shift, compare and add/sub complete in one cycle.
//            Unsigned multiply and divide run iteratively, one bit per cycle,
//            when the ALU_MULDIV_EN macro is defined. Without it, MULU/DIVU
//            report illegal_op and the iterative datapath is absent.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready, op[3:0], operand_a, operand_b  - request side
//            out_valid/out_ready, result, result_hi            - response side
//            zero, negative, overflow, div_by_zero, illegal_op - status flags
// Macro    : ALU_MULDIV_EN - enables the MULU/DIVU iterative datapath
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath, evaluated directly from the request ports so the
  // result can be registered on the accepting edge.
  // --------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               a_msb, b_msb, s_msb;
  logic [WIDTH-1:0]   calc_res, calc_hi;
  logic               calc_ovf, calc_dbz, calc_ill, calc_iter;

  assign shamt = operand_b[SHAMT_W-1:0];
  // op[0] selects subtract for the ADD/SUB/ADDU/SUBU group: A + ~B + 1.
  assign add_b = op[0] ? ~operand_b : operand_b;
  assign sum   = operand_a + add_b + {{(WIDTH-1){1'b0}}, op[0]};
  assign a_msb = operand_a[WIDTH-1];
  assign b_msb = operand_b[WIDTH-1];
  assign s_msb = sum[WIDTH-1];

  always_comb begin
    calc_res  = '0;
    calc_hi   = '0;
    calc_ovf  = 1'b0;
    calc_dbz  = 1'b0;
    calc_ill  = 1'b0;
    calc_iter = 1'b0;
    case (op)
      OP_ADD: begin
        calc_res = sum;
        calc_ovf = (a_msb == b_msb) && (s_msb != a_msb);
      end
      OP_SUB: begin
        calc_res = sum;
        calc_ovf = (a_msb != b_msb) && (s_msb != a_msb);
      end
      OP_ADDU, OP_SUBU: calc_res = sum;
      OP_AND:  calc_res = operand_a & operand_b;
      OP_OR:   calc_res = operand_a | operand_b;
      OP_XOR:  calc_res = operand_a ^ operand_b;
      OP_NOR:  calc_res = ~(operand_a | operand_b);
      OP_SLL:  calc_res = operand_a << shamt;
      OP_SRL:  calc_res = operand_a >> shamt;
      OP_SRA:  calc_res = $signed(operand_a) >>> shamt;
      OP_SLT:  calc_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: calc_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
`ifdef ALU_MULDIV_EN
      OP_MULU: calc_iter = 1'b1;
      OP_DIVU: begin
        if (operand_b == '0) begin
          // Divide by zero finishes immediately with a fixed result.
          calc_res = '1;
          calc_hi  = operand_a;
          calc_dbz = 1'b1;
        end else begin
          calc_iter = 1'b1;
        end
      end
      OP_RSVD: calc_ill = 1'b1;
`else
      OP_MULU, OP_DIVU, OP_RSVD: calc_ill = 1'b1;
`endif
      default: calc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // --------------------------------------------------------------------------
  // Iterative datapath. acc_hi/acc_lo form a 2*WIDTH shift register:
  //   MULU: acc_lo starts as the multiplier, acc_hi accumulates partial sums;
  //         each step adds the multiplicand when acc_lo[0] is set, then
  //         shifts {carry, acc_hi, acc_lo} right by one.
  //   DIVU: acc_lo starts as the dividend and fills with quotient bits,
  //         acc_hi holds the partial remainder (restoring division).
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    // A borrow out of the top bit means the divisor did not fit.
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
`ifdef ALU_MULDIV_EN
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (calc_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              is_div    <= (op == OP_DIVU);
              acc_hi    <= '0;
              acc_lo    <= (op == OP_DIVU) ? operand_a : operand_b;
              opnd      <= (op == OP_DIVU) ? operand_b : operand_a;
              cnt       <= CNT_W'(WIDTH);
            end else
`endif
            begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= calc_res;
              result_hi   <= calc_hi;
              zero        <= (calc_res == '0) && !calc_ill;
              negative    <= calc_res[WIDTH-1];
              overflow    <= calc_ovf;
              div_by_zero <= calc_dbz;
              illegal_op  <= calc_ill;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MULDIV_EN
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= step_lo;
            result_hi   <= step_hi;
            zero        <= (step_lo == '0);
            negative    <= step_lo[WIDTH-1];
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (default parameters, WIDTH=32).
//            Follows ALU_MULDIV_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, result_hi;
  logic        zero, negative, overflow, div_by_zero, illegal_op;
  logic [68:0] got;

  int n_vec = 0;
  int n_err = 0;

  alu_mc dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .zero(zero), .negative(negative), .overflow(overflow),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign got = {result, result_hi, zero, negative, overflow, div_by_zero, illegal_op};

  // Reference model: {result, result_hi, zero, negative, overflow, dbz, illegal}
  function automatic logic [68:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r, rh;
    logic        v, dz, il;
    longint      sa, sb, s;
    logic [63:0] p;
    int          sh;
    r = 0; rh = 0; v = 0; dz = 0; il = 0; p = 0; s = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (o)
      4'd0:  begin s = sa + sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd1:  begin s = sa - sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = $signed(a) >>> sh;
      4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      4'd13: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; rh = p[63:32]; end
      4'd14: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; rh = a; dz = 1; end
        else begin r = a / b; rh = a % b; end
      end
`endif
      default: il = 1;
    endcase
    return {r, rh, (r == 0) && !il, r[31] && !il, v, dz, il};
  endfunction

  function automatic int model_latency(input logic [3:0] o, input logic [31:0] b);
`ifdef ALU_MULDIV_EN
    if (o == 4'd13 || (o == 4'd14 && b != 0)) return 32;
`endif
    return 0;
  endfunction

  // Drives one request with out_ready=1, waits for its response; latency is
  // counted in clock edges after the accepting edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit rdy_busy, output bit tmo);
    int w;
    w = 0; lat = 0; rdy_busy = 0; tmo = 0;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; in_valid = 1; out_ready = 1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) tmo = 1;
    @(posedge clk); #1;
    in_valid = 0;
    // Scramble the request ports: the captured operation must not depend on them.
    op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy = 1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) tmo = 1;
  endtask

  task automatic test_reset;
    reset = 1; in_valid = 0; out_ready = 0; op = 0; operand_a = 0; operand_b = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (got !== 69'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h valid=%b exp=0 valid=0", got, out_valid);
    end
    @(negedge clk); reset = 0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single;
    logic [3:0]  t_op [9] = '{4'd0, 4'd1, 4'd1, 4'd10, 4'd11, 4'd12, 4'd15, 4'd7, 4'd8};
    logic [31:0] t_a  [9] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hF000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0F0F_0000, 32'd3};
    logic [31:0] t_b  [9] = '{32'd1, 32'd5, 32'd1, 32'd4, 32'd1, 32'd1,
                              32'h9ABC_DEF0, 32'h0000_F0F0, 32'd31};
    int lat; bit rdy, tmo; logic [68:0] exp;
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, rdy, tmo);
      exp = model(t_op[i], t_a[i], t_b[i]);
      n_vec++;
      if (tmo || got !== exp) begin
        n_err++;
        $display("FAIL single op=%0d a=%h b=%h got=%h exp=%h tmo=%b", t_op[i], t_a[i], t_b[i], got, exp, tmo);
      end
      n_vec++;
      if (lat !== 0) begin
        n_err++; $display("FAIL single_latency op=%0d got=%0d exp=0", t_op[i], lat);
      end
    end
  endtask

  task automatic test_muldiv;
    logic [3:0]  t_op [5] = '{4'd13, 4'd14, 4'd14, 4'd13, 4'd14};
    logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'd100, 32'd9, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] t_b  [5] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_0000};
    int lat, el; bit rdy, tmo; logic [68:0] exp;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, rdy, tmo);
      exp = model(t_op[i], t_a[i], t_b[i]);
      el  = model_latency(t_op[i], t_b[i]);
      n_vec++;
      if (tmo || got !== exp) begin
        n_err++;
        $display("FAIL muldiv op=%0d a=%h b=%h got=%h exp=%h tmo=%b", t_op[i], t_a[i], t_b[i], got, exp, tmo);
      end
      n_vec++;
      if (lat !== el) begin
        n_err++; $display("FAIL muldiv_latency op=%0d got=%0d exp=%0d", t_op[i], lat, el);
      end
      if (el > 0) begin
        n_vec++;
        if (rdy) begin
          n_err++; $display("FAIL busy_in_ready op=%0d got=1 exp=0", t_op[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b; logic [68:0] exp; int w;
    a = $urandom; b = $urandom; w = 0;
    @(negedge clk);
    op = 4'd4; operand_a = a; operand_b = b; in_valid = 1; out_ready = 1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    exp = model(4'd4, a, b);
    n_vec++;
    if (out_valid !== 1'b1 || got !== exp) begin
      n_err++; $display("FAIL bp_and got=%h valid=%b exp=%h", got, out_valid, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || got !== exp || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got=%h valid=%b in_ready=%b exp=%h valid=1 in_ready=0",
                 i, got, out_valid, in_ready, exp);
      end
    end
    a = $urandom; b = $urandom;
    @(negedge clk);
    op = 4'd5; operand_a = a; operand_b = b; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    exp = model(4'd5, a, b);
    n_vec++;
    if (out_valid !== 1'b1 || got !== exp) begin
      n_err++; $display("FAIL bp_back_to_back_or got=%h valid=%b exp=%h", got, out_valid, exp);
    end
  endtask

  task automatic test_random;
    logic [3:0] o; logic [31:0] a, b; int lat, el; bit rdy, tmo; logic [68:0] exp;
    for (int i = 0; i < 120; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $urandom_range(1, 40);
        3:       b = a;
        default: b = $urandom;
      endcase
      run_op(o, a, b, lat, rdy, tmo);
      exp = model(o, a, b);
      el  = model_latency(o, b);
      n_vec++;
      if (tmo || got !== exp || lat !== el) begin
        n_err++;
        $display("FAIL random op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", o, a, b, got, lat, exp, el);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit rdy, tmo, seen; logic [68:0] exp; logic [31:0] a, b;
    @(negedge clk);
`ifdef ALU_MULDIV_EN
    op = 4'd13; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
`else
    op = 4'd4; operand_a = 32'hFFFF_FFFF; operand_b = 32'h1234_5678;
`endif
    in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1; reset = 1; #1;
    n_vec++;
    if (got !== 69'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got=%h valid=%b exp=0 valid=0", got, out_valid);
    end
    @(negedge clk); reset = 0; out_ready = 1; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_in_ready got=%b exp=1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    n_vec++;
    if (seen) begin
      n_err++; $display("FAIL reset_mid_abort got=valid exp=no_valid");
    end
    a = $urandom; b = $urandom;
    run_op(4'd0, a, b, lat, rdy, tmo);
    exp = model(4'd0, a, b);
    n_vec++;
    if (tmo || got !== exp || lat !== 0) begin
      n_err++; $display("FAIL reset_mid_next got=%h lat=%0d exp=%h lat=0", got, lat, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU.
- Accepts one operation per valid/ready handshake and executes logic, shift, compare and add/sub ops in one cycle.
- Executes unsigned multiply and divide iteratively, one bit per cycle.
- Result and flags are held until the consumer accepts them, so the block sits between decode/issue and writeback in a multi-cycle or pipelined datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 8).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- op  input  4  operation code, see Behaviour
- operand_a  input  WIDTH  source A
- operand_b  input  WIDTH  source B; B[SHAMT_W-1:0] is the shift amount for shifts
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  primary result (low product / quotient)
- result_hi  output  WIDTH  high product (MULU) / remainder (DIVU), 0 otherwise
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow, ADD/SUB only
- div_by_zero  output  1  DIVU with B == 0
- illegal_op  output  1  reserved or compiled-out opcode

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB (signed, overflow flagged).
  - 0010 ADDU, 0011 SUBU (modular, overflow=0).
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1011 SLT (signed), 1100 SLTU; result 1 or 0, zero-extended.
  - 1101 MULU, 1110 DIVU, 1111 reserved.
- All arithmetic is two's complement, modulo 2^WIDTH. SUB is A + ~B + 1; no sign-case special-casing.
- ADD overflow = A and B have the same sign and the result sign differs.
- SUB overflow = A and B signs differ and the result sign differs from A.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- A request is accepted when in_valid && in_ready. Operands and op are captured into internal registers; the input ports are not used after acceptance.
- Single-cycle op accepted at edge N: result/flags registered at N, out_valid=1 from N onward, state=DONE.
- MULU/DIVU accepted at edge N:
  - State becomes BUSY and the counter is loaded with WIDTH.
  - One shift-add (MULU) or restoring subtract-shift (DIVU) step runs per cycle.
  - Transition to DONE with out_valid=1 exactly WIDTH cycles after acceptance.
- MULU: {result_hi, result} = full 2*WIDTH-bit unsigned product.
- DIVU: result = A / B, result_hi = A % B.
- DIVU with B == 0: skip BUSY and complete in one cycle with result = all ones, result_hi = A, div_by_zero = 1.
- DONE: result and flags stay stable while out_valid && !out_ready.
  - On out_ready with no new request: go to IDLE, out_valid=0.
  - On out_ready with a simultaneous accepted request: the new op is captured in the same edge (back-to-back, no bubble). The next state is DONE (single-cycle op) or BUSY (MULU/DIVU).
- BUSY: in_ready=0; out_ready is ignored.
- Opcode 1111: completes in one cycle with result = 0, result_hi = 0, illegal_op = 1, all other flags 0.
- Flags not applicable to the current op are 0.
- zero and negative are derived from result only.
- Reset, asserted at any time including mid-BUSY:
  - The operation is aborted and state goes to IDLE.
  - out_valid=0; result, result_hi and all flags are 0; in_ready=1 once reset deasserts.
  - The counter is cleared.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MULU/DIVU behave as above and the iterative datapath is present.
- Undefined: no iterative datapath and no BUSY state. Opcodes 1101/1110 complete in one cycle as illegal (result = 0, illegal_op = 1, div_by_zero = 0). All other ops are unchanged.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001, out_ready=1 -> next cycle result=0x80000000, overflow=1, negative=1, zero=0.
- SUB A=0x00000005, B=0x00000005 -> result=0, zero=1, overflow=0; then SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, overflow=1.
- SRA A=0xF0000000, B=4 -> result=0xFF000000. SLT A=0xFFFFFFFF, B=1 -> result 1. SLTU with the same operands -> result 0.
- MULU A=0xFFFFFFFF, B=0x00000002 -> out_valid exactly 32 cycles after acceptance, result=0xFFFFFFFE, result_hi=0x00000001. in_ready=0 throughout BUSY.
- DIVU A=100, B=7 -> result=14, result_hi=2 after 32 cycles. DIVU A=9, B=0 -> one-cycle result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles after an AND -> result stable, in_ready=0.
  - Then out_ready=1 together with a new valid OR -> OR result appears on the next edge.
  - Assert reset during a MULU BUSY cycle -> out_valid=0, all outputs 0, next request accepted normally.
